hazard_ctrl: RTL

Pipeline hazard and sequencing controller for the five-stage 16-bit core. It drives the write-enable and flush controls of the IF/ID pipeline register, the PC write enable, and the ID/EX bubble insert. It resolves load-use stalls, taken-branch/jump flushes, memory-busy freezes, and halt drain. It also keeps saturating stall and flush event counters for debug.

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard and sequencing controller for the five-stage 16-bit core
// Resolves memory freezes, redirects, load-use stalls and halt drain; keeps saturating debug counters.
module hazard_ctrl #(
  parameter int REG_BITS     = 3,
  parameter int FLUSH_EXTRA  = 0,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_BITS     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IDEX_MemRead,
  input  logic [REG_BITS-1:0] IDEX_Rd,
  input  logic [REG_BITS-1:0] IFID_Rs,
  input  logic [REG_BITS-1:0] IFID_Rt,
  input  logic                IFID_RsValid,
  input  logic                IFID_RtValid,
  input  logic                BranchTaken,
  input  logic                HaltInID,
  input  logic                MemStall,
  output logic                PCWrite,
  output logic                IFWrite,
  output logic                IFFlush,
  output logic                IDEXBubble,
  output logic                PipeWrite,
  output logic                Halted,
  output logic [CNT_BITS-1:0] StallCnt,
  output logic [CNT_BITS-1:0] FlushCnt
);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALT} state_t;

  localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_EXTRA);
  localparam logic [2:0]          DRAIN_LOAD = 3'(DRAIN_CYCLES);
  localparam logic [CNT_BITS-1:0] CNT_ONE    = CNT_BITS'(1);

  state_t     state, stateNext;
  logic [2:0] cnt, cntNext;
  logic       stallEv, flushEv;
  logic       loadUse;

  assign loadUse = IDEX_MemRead &
                   ((IFID_RsValid & (IFID_Rs == IDEX_Rd)) |
                    (IFID_RtValid & (IFID_Rt == IDEX_Rd)));

  assign Halted = (state == HALT);

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    PCWrite    = 1'b1;
    IFWrite    = 1'b1;
    IFFlush    = 1'b0;
    IDEXBubble = 1'b0;
    PipeWrite  = 1'b1;
    stallEv    = 1'b0;
    flushEv    = 1'b0;

    if (state == HALT) begin
      PCWrite   = 1'b0;
      IFWrite   = 1'b0;
      PipeWrite = 1'b0;
    end else if (MemStall) begin
      // EX is frozen, so a pending branch is re-presented once the stall drops
      PCWrite   = 1'b0;
      IFWrite   = 1'b0;
      PipeWrite = 1'b0;
      stallEv   = 1'b1;
    end else if (BranchTaken) begin
      IFFlush    = 1'b1;
      IDEXBubble = 1'b1;
      flushEv    = 1'b1;
      if (FLUSH_LOAD != 3'd0) begin
        stateNext = FLUSH;
        cntNext   = FLUSH_LOAD;
      end else begin
        stateNext = RUN;
        cntNext   = 3'd0;
      end
    end else begin
      case (state)
        FLUSH: begin
          IFFlush    = 1'b1;
          IDEXBubble = 1'b1;
          if (cnt <= 3'd1) begin
            stateNext = RUN;
            cntNext   = 3'd0;
          end else begin
            cntNext = cnt - 3'd1;
          end
        end
        DRAIN: begin
          // ID holds a NOP here, so load-use cannot occur
          PCWrite = 1'b0;
          IFFlush = 1'b1;
          if (cnt <= 3'd1) begin
            stateNext = HALT;
            cntNext   = 3'd0;
          end else begin
            cntNext = cnt - 3'd1;
          end
        end
        default: begin
          if (loadUse) begin
            PCWrite    = 1'b0;
            IFWrite    = 1'b0;
            IDEXBubble = 1'b1;
            stallEv    = 1'b1;
          end else if (HaltInID) begin
            PCWrite   = 1'b0;
            IFFlush   = 1'b1;
            stateNext = DRAIN;
            cntNext   = DRAIN_LOAD;
          end
        end
      endcase
    end

    // Reset keeps NOPs flowing through every stage
    if (rst) begin
      PCWrite    = 1'b0;
      IFWrite    = 1'b1;
      IFFlush    = 1'b1;
      IDEXBubble = 1'b1;
      PipeWrite  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      cnt      <= 3'd0;
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (stallEv && (StallCnt != '1)) StallCnt <= StallCnt + CNT_ONE;
      if (flushEv && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_ONE;
    end
  end

endmodule
